cache_i_assoc: RTL and testbench
================================

# cache_i_assoc

Parametrised set-associative, read-only instruction cache between the IF stage and the instruction memory port. Generalises the direct-mapped instruction cache in line size, set count and associativity. Adds per-set round-robin replacement and a single-cycle whole-cache invalidate (`cache_flush`). Processor- and memory-side port names match the existing cache so it drops into the core unchanged.

## Interface
Parameters:
- `ADDR_W`, 30: processor word-address width.
- `DATA_W`, 32: word width.
- `WORDS`, 4: words per line; power of 2, ≥2.
- `SETS`, 8: number of sets; power of 2, ≥2.
- `WAYS`, 2: associativity; power of 2, ≥1.
- Derived widths:
  - OFF = log2(WORDS)
  - IDX = log2(SETS)
  - TAG = ADDR_W−IDX−OFF
  - line = DATA_W·WORDS bits

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `proc_reset`  in  1  asynchronous, active-high reset.
- `proc_stall`  out  1  processor must hold its request.
- `proc_addr`  in  ADDR_W  word address.
- `proc_read`  in  1  fetch request.
- `proc_rdata`  out  DATA_W  fetched word.
- `proc_write`  in  1  ignored (read-only cache).
- `proc_wdata`  in  DATA_W  ignored.
- `cache_flush`  in  1  invalidate all lines.
- `mem_addr`  out  ADDR_W−OFF  line address.
- `mem_read`  out  1  line fetch request.
- `mem_rdata`  in  DATA_W·WORDS  returned line; word i at bits [DATA_W·i +: DATA_W].
- `mem_write`  out  1  tied 0.
- `mem_wdata`  out  DATA_W·WORDS  tied 0.
- `mem_ready`  in  1  `mem_rdata` valid this cycle.

## Operation
- Address split: offset = `proc_addr[OFF-1:0]`, index = next IDX bits, tag = upper TAG bits.
- Storage per set per way: valid bit, tag, line. One round-robin pointer per set, log2(WAYS) bits; none when WAYS=1.
- FSM states: IDLE, REFILL.
- **IDLE**
  - Hit = `proc_read` and some way in the indexed set has valid and tag match.
  - On hit: `proc_rdata` = selected word, combinationally; `proc_stall`=0.
  - On miss with `proc_read`=1: `proc_stall`=1 combinationally. Latch line address {tag,index} into `mem_addr` register. Go to REFILL.
  - With `proc_read`=0: `proc_stall`=0, `proc_rdata`=0.
- **REFILL**
  - `mem_read`=1 and `proc_stall`=1. `mem_addr` is held constant.
  - On a cycle with `mem_ready`=1:
    - Select the victim: lowest-numbered invalid way; if all ways are valid, way = rr[index], then rr[index] ← rr[index]+1 mod WAYS.
    - Write line, tag and valid=1 into the victim.
    - Drop `mem_read` and return to IDLE.
  - The processor holds its address, so the next IDLE cycle hits.
- The processor must hold `proc_addr` and `proc_read` while `proc_stall`=1. Address changes during REFILL are ignored until IDLE.
- **Flush**
  - In IDLE: `cache_flush`=1 clears every valid bit at the edge. rr pointers are unchanged.
  - `cache_flush` has priority over a simultaneous hit for state, but the hit data in that same cycle is still returned.
  - Flush during REFILL sets a pending flag. On refill completion the line is written, then all valid bits (including the new line) are cleared. The FSM returns to IDLE, where the access misses again.
- `proc_write`/`proc_wdata` have no effect; `mem_write`=0 and `mem_wdata`=0 always.

## Timing
- Reset is asynchronous. While `proc_reset`=1 and after release:
  - state IDLE; all valid bits, rr pointers and the flush-pending flag = 0.
  - `mem_read`=0, `mem_addr`=0, `proc_stall`=0 (forced while `proc_reset`=1), `proc_rdata`=0.
- Reset mid-REFILL: `mem_read` falls immediately without waiting for a clock. The partial refill is discarded.
- Hit latency is 0 cycles (combinational read).
- Miss timing with `mem_ready` first high W cycles after REFILL entry (W≥0):
  - `proc_stall` is high for 2+W cycles.
  - Data appears in the cycle `proc_stall` falls.
- `mem_ready` is sampled only in REFILL and ignored in IDLE.

## Test plan
- **Cold miss:** reset; read 0x10.
  - `proc_stall`=1, next cycle `mem_read`=1 with `mem_addr`=0x4.
  - Hold `mem_ready` low 3 cycles, then return line {0xD3,0xD2,0xD1,0xD0}.
  - Next cycle: `proc_stall`=0, `proc_rdata`=0xD0. Read 0x11 → 0xD1 with no stall.
- **Associativity / round-robin** (WAYS=2):
  - Fill 0x10, 0x30, 0x50 (all index 4, tags 0, 1, 2): 0x10 → way0, 0x30 → way1, 0x50 evicts way0 (rr 0→1).
  - Then 0x30 hits, 0x10 misses and evicts way1.
- **Flush in IDLE:** after 0x10 hits, pulse `cache_flush` → next read of 0x10 stalls and sets `mem_read`=1.
- **Flush during REFILL:** assert `cache_flush` while `mem_read`=1, then `mem_ready`=1 → after IDLE, the same access misses again and issues a second `mem_read`.
- **Reset mid-REFILL:** assert `proc_reset` between edges while `mem_read`=1 → `mem_read`=0 immediately; after release, read 0x10 misses.
- **Write ignored:** `proc_write`=1, `proc_read`=0, `proc_wdata`=0xFFFFFFFF → `proc_stall`=0, `mem_write`=0, and a following read of a cached line returns the original data.

Source files
------------

// File: rtl/cache_i_assoc.sv
// Set-associative read-only instruction cache with per-set round-robin
// replacement and a single-cycle whole-cache invalidate.
module cache_i_assoc #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int WORDS  = 4,
  parameter int SETS   = 8,
  parameter int WAYS   = 2
) (
  input  logic                      clk,
  input  logic                      proc_reset,
  output logic                      proc_stall,
  input  logic [ADDR_W-1:0]         proc_addr,
  input  logic                      proc_read,
  output logic [DATA_W-1:0]         proc_rdata,
  input  logic                      proc_write,
  input  logic [DATA_W-1:0]         proc_wdata,
  input  logic                      cache_flush,
  output logic [ADDR_W-$clog2(WORDS)-1:0] mem_addr,
  output logic                      mem_read,
  input  logic [DATA_W*WORDS-1:0]   mem_rdata,
  output logic                      mem_write,
  output logic [DATA_W*WORDS-1:0]   mem_wdata,
  input  logic                      mem_ready
);

  localparam int OFF   = $clog2(WORDS);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG   = ADDR_W - IDX - OFF;
  localparam int LINE  = DATA_W * WORDS;
  localparam int LA_W  = ADDR_W - OFF;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t            state_q;
  logic [LA_W-1:0]   mem_addr_q;
  logic              mem_read_q;
  logic              flush_pend_q;
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [TAG-1:0]    tag_q   [SETS][WAYS];
  logic [LINE-1:0]   line_q  [SETS][WAYS];

  // Processor-side address fields
  logic [OFF-1:0] p_off;
  logic [IDX-1:0] p_idx;
  logic [TAG-1:0] p_tag;
  assign p_off = proc_addr[OFF-1:0];
  assign p_idx = proc_addr[OFF +: IDX];
  assign p_tag = proc_addr[ADDR_W-1 -: TAG];

  // Refill target fields come from the latched line address, not proc_addr
  logic [IDX-1:0] r_idx;
  logic [TAG-1:0] r_tag;
  assign r_idx = mem_addr_q[IDX-1:0];
  assign r_tag = mem_addr_q[LA_W-1 -: TAG];

  logic              lk_hit;
  logic [LINE-1:0]   lk_line;
  logic [DATA_W-1:0] lk_word;
  logic [WAY_W-1:0]  victim;
  logic              all_valid;
  logic              idle_hit;
  logic              idle_miss;

  // Tag compare across all ways of the indexed set, then word select
  always_comb begin
    lk_hit  = 1'b0;
    lk_line = '0;
    lk_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[p_idx][w] && (tag_q[p_idx][w] == p_tag)) begin
        lk_hit  = 1'b1;
        lk_line = line_q[p_idx][w];
      end
    end
    for (int i = 0; i < WORDS; i++) begin
      if (p_off == OFF'(i)) lk_word = lk_line[DATA_W*i +: DATA_W];
    end
  end

  // Victim: lowest-numbered invalid way, else the set's round-robin pointer
  always_comb begin
    victim    = rr_q[r_idx];
    all_valid = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[r_idx][w]) begin
        victim    = WAY_W'(w);
        all_valid = 1'b0;
      end
    end
  end

  assign idle_hit  = (state_q == IDLE) && proc_read && lk_hit;
  assign idle_miss = (state_q == IDLE) && proc_read && !lk_hit;

  assign proc_stall = proc_reset ? 1'b0 : ((state_q == REFILL) || idle_miss);
  assign proc_rdata = idle_hit ? lk_word : '0;
  assign mem_addr   = mem_addr_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = 1'b0;
  assign mem_wdata  = '0;

  // Writes are not supported; these inputs are deliberately consumed here
  logic unused_write;
  assign unused_write = ^{proc_write, proc_wdata};

  // Control FSM, valid bits and round-robin pointers
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_read_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cache_flush) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
          end
          if (idle_miss) begin
            mem_addr_q <= {p_tag, p_idx};
            mem_read_q <= 1'b1;
            state_q    <= REFILL;
          end
        end
        REFILL: begin
          if (cache_flush) flush_pend_q <= 1'b1;
          if (mem_ready) begin
            valid_q[r_idx][victim] <= 1'b1;
            if (all_valid && (WAYS > 1)) rr_q[r_idx] <= rr_q[r_idx] + 1'b1;
            // A flush seen during the refill wipes everything, new line included
            if (flush_pend_q || cache_flush) begin
              for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
            end
            flush_pend_q <= 1'b0;
            mem_read_q   <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and line storage; validity is governed by valid_q alone
  always_ff @(posedge clk) begin
    if ((state_q == REFILL) && mem_ready) begin
      tag_q[r_idx][victim]  <= r_tag;
      line_q[r_idx][victim] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_cache_i_assoc.sv
// Scoreboard bench for cache_i_assoc: directed scenarios plus random fetches
// checked against a behavioural set/way model.
module tb_cache_i_assoc;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int WORDS  = 4;
  localparam int SETS   = 8;
  localparam int WAYS   = 2;

  logic                    clk = 1'b0;
  logic                    proc_reset;
  logic                    proc_stall;
  logic [ADDR_W-1:0]       proc_addr;
  logic                    proc_read;
  logic [DATA_W-1:0]       proc_rdata;
  logic                    proc_write;
  logic [DATA_W-1:0]       proc_wdata;
  logic                    cache_flush;
  logic [ADDR_W-3:0]       mem_addr;
  logic                    mem_read;
  logic [DATA_W*WORDS-1:0] mem_rdata;
  logic                    mem_write;
  logic [DATA_W*WORDS-1:0] mem_wdata;
  logic                    mem_ready;

  cache_i_assoc #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .proc_reset(proc_reset), .proc_stall(proc_stall), .proc_addr(proc_addr),
    .proc_read(proc_read), .proc_rdata(proc_rdata), .proc_write(proc_write),
    .proc_wdata(proc_wdata), .cache_flush(cache_flush), .mem_addr(mem_addr),
    .mem_read(mem_read), .mem_rdata(mem_rdata), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                refills;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   stall_cnt = 0;
  int   stall_exp = 0;
  int   refills_seen = 0;
  int   force_w = -1;

  // Reference model: per set, WAYS slots of (valid, tag) and a round-robin pointer
  bit   m_valid [SETS][WAYS];
  int   m_tag   [SETS][WAYS];
  int   m_rr    [SETS];

  function automatic logic [DATA_W-1:0] memword(input logic [ADDR_W-1:0] a);
    return ({2'b00, a} * 32'h0000_9E37) ^ 32'hD0D0_5A5A;
  endfunction

  function automatic void m_flush();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
  endfunction

  function automatic void m_reset();
    m_flush();
    for (int s = 0; s < SETS; s++) m_rr[s] = 0;
  endfunction

  // Returns 1 on hit; on miss installs the line following the replacement rule
  function automatic bit model_access(input logic [ADDR_W-1:0] a);
    int idx;
    int tag;
    int v;
    idx = int'(a[4:2]);
    tag = int'(a[ADDR_W-1:5]);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[idx][w] && m_tag[idx][w] == tag) return 1'b1;
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[idx][w]) begin
        m_valid[idx][w] = 1'b1;
        m_tag[idx][w]   = tag;
        return 1'b0;
      end
    v = m_rr[idx];
    m_tag[idx][v] = tag;
    m_rr[idx] = (v + 1) % WAYS;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
    end
  endtask

  // Memory responder: serves each refill after W cycles of mem_ready low
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_read && !proc_reset) begin
        int w;
        bit abort;
        logic [ADDR_W-3:0] la;
        w = (force_w >= 0) ? force_w : int'($urandom_range(0, 3));
        la = mem_addr;
        abort = 1'b0;
        if (exp_q.size() > 0) chk("mem_addr", 64'(mem_addr), 64'(exp_q[0].addr[ADDR_W-1:2]));
        for (int k = 0; k < w; k++) begin
          @(negedge clk);
          if (proc_reset) begin
            abort = 1'b1;
            break;
          end
          chk("mem_addr_hold", 64'(mem_addr), 64'(la));
          chk("mem_read_hold", 64'(mem_read), 64'd1);
        end
        if (!abort && !proc_reset) begin
          for (int i = 0; i < WORDS; i++) begin
            logic [1:0] off;
            off = 2'(i);
            mem_rdata[DATA_W*i +: DATA_W] = memword({la, off});
          end
          mem_ready = 1'b1;
          refills_seen++;
          stall_exp += 2 + w;
          @(negedge clk);
          mem_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: counts stall cycles and retires one scoreboard entry per accepted fetch
  initial begin
    forever begin
      @(negedge clk);
      if (!proc_reset) begin
        if (proc_read) begin
          if (proc_stall) stall_cnt++;
          else begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL accept_without_request addr=%0h actual=accept required=none", proc_addr);
            end else begin
              e = exp_q.pop_front();
              chk("rdata", 64'(proc_rdata), 64'(e.data));
              chk("refills", 64'(refills_seen), 64'(e.refills));
              chk("stall_cycles", 64'(stall_cnt), 64'(stall_exp));
              chk("mem_write", 64'(mem_write), 64'd0);
              chk("mem_wdata", 64'(mem_wdata[63:0] | mem_wdata[127:64]), 64'd0);
              $display("rd addr=%0h data=%0h refills=%0d stall=%0d", e.addr, proc_rdata, refills_seen, stall_cnt);
            end
            stall_cnt = 0;
            stall_exp = 0;
            refills_seen = 0;
          end
        end else begin
          chk("idle_stall", 64'(proc_stall), 64'd0);
          chk("idle_rdata", 64'(proc_rdata), 64'd0);
          chk("idle_mem_read", 64'(mem_read), 64'd0);
        end
      end
    end
  end

  // Issue one fetch and hold it until accepted; exp_ref<0 means ask the model
  task automatic do_read(input logic [ADDR_W-1:0] a, input int exp_ref, input bit flush_with);
    exp_t n;
    bit hit;
    bit done;
    hit = model_access(a);
    if (flush_with) m_flush();
    n.addr = a;
    n.data = memword(a);
    n.refills = (exp_ref >= 0) ? exp_ref : (hit ? 0 : 1);
    exp_q.push_back(n);
    proc_addr = a;
    proc_read = 1'b1;
    proc_write = 1'b0;
    cache_flush = flush_with;
    done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!proc_stall) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout addr=%0h actual=stalled required=accept", a);
    end
    @(posedge clk); #1;
    proc_read = 1'b0;
    cache_flush = 1'b0;
  endtask

  task automatic idle_cycle(input bit flush);
    proc_read = 1'b0;
    proc_write = $urandom_range(0, 1) == 1;
    proc_wdata = $urandom;
    cache_flush = flush;
    if (flush) m_flush();
    @(posedge clk); #1;
    cache_flush = 1'b0;
    proc_write = 1'b0;
  endtask

  task automatic wait_mem_read();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_read) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL mem_read_timeout actual=0 required=1");
    end
  endtask

  initial begin
    exp_t n;
    bit done;
    proc_reset = 1'b1;
    proc_addr = 30'h10;
    proc_read = 1'b1;
    proc_write = 1'b0;
    proc_wdata = '0;
    cache_flush = 1'b0;
    m_reset();
    #3;
    chk("rst_stall", 64'(proc_stall), 64'd0);
    chk("rst_mem_read", 64'(mem_read), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_rdata", 64'(proc_rdata), 64'd0);
    proc_read = 1'b0;
    repeat (2) @(posedge clk);
    #1 proc_reset = 1'b0;

    // Cold miss with three wait cycles, then a neighbouring word hits
    force_w = 3;
    do_read(30'h10, 1, 1'b0);
    force_w = -1;
    do_read(30'h11, 0, 1'b0);

    // Round-robin: fill both ways of set 4, then evict in order
    do_read(30'h30, 1, 1'b0);
    do_read(30'h50, 1, 1'b0);
    do_read(30'h30, 0, 1'b0);
    do_read(30'h10, 1, 1'b0);
    do_read(30'h13, 0, 1'b0);

    // Write attempt has no effect on cached data
    proc_write = 1'b1;
    proc_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("write_stall", 64'(proc_stall), 64'd0);
    chk("write_mem_write", 64'(mem_write), 64'd0);
    @(posedge clk); #1;
    proc_write = 1'b0;
    do_read(30'h10, 0, 1'b0);

    // Flush together with a hit still returns the word; next access misses
    do_read(30'h12, 0, 1'b1);
    do_read(30'h12, 1, 1'b0);
    idle_cycle(1'b1);
    do_read(30'h10, 1, 1'b0);

    // Flush while a refill is outstanding forces a second refill
    m_flush();
    void'(model_access(30'h70));
    n.addr = 30'h70;
    n.data = memword(30'h70);
    n.refills = 2;
    exp_q.push_back(n);
    force_w = 3;
    proc_addr = 30'h70;
    proc_read = 1'b1;
    wait_mem_read();
    cache_flush = 1'b1;
    @(negedge clk);
    cache_flush = 1'b0;
    force_w = -1;
    done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!proc_stall) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL flush_refill_timeout actual=stalled required=accept");
    end
    @(posedge clk); #1;
    proc_read = 1'b0;

    // Reset in the middle of a refill drops mem_read at once
    force_w = 3;
    void'(model_access(30'h90));
    n.addr = 30'h90;
    n.data = memword(30'h90);
    n.refills = 1;
    exp_q.push_back(n);
    proc_addr = 30'h90;
    proc_read = 1'b1;
    wait_mem_read();
    #2 proc_reset = 1'b1;
    #1;
    chk("midrst_mem_read", 64'(mem_read), 64'd0);
    chk("midrst_stall", 64'(proc_stall), 64'd0);
    chk("midrst_rdata", 64'(proc_rdata), 64'd0);
    proc_read = 1'b0;
    exp_q.delete();
    stall_cnt = 0;
    stall_exp = 0;
    refills_seen = 0;
    force_w = -1;
    m_reset();
    repeat (2) @(posedge clk);
    #1 proc_reset = 1'b0;
    do_read(30'h10, 1, 1'b0);

    // Random traffic over a few sets and tags
    for (int t = 0; t < 300; t++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'(($urandom_range(0, 3) << 5) | ($urandom_range(3, 4) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 9) < 3) idle_cycle($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) begin
        int idx;
        int tag;
        bit hit;
        idx = int'(a[4:2]);
        tag = int'(a[ADDR_W-1:5]);
        hit = 1'b0;
        for (int w = 0; w < WAYS; w++)
          if (m_valid[idx][w] && m_tag[idx][w] == tag) hit = 1'b1;
        do_read(a, -1, hit);
      end else begin
        do_read(a, -1, 1'b0);
      end
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
